exec_seq: RTL
=============

// Module: exec_seq
// PURPOSE
//  Execution-phase sequencer for the P-D instruction decoder: holds the one-hot execution state
//  (PP, WE, WR, WP, WA, WZ, W$, WX, WM, WW) and runs a strobe timing FSM for each state.
//  Outputs: STROB1/STROB1B/STROB2/GOT.
//  At the end of every state cycle it samples the decoder's enter signals (ew*) and cycle-end signals (ekc_*),
//  then selects the next state or signals cycle end (KC) back to the fetch/control unit.
// PARAMETERS
//  STROB_LEN    2    clk cycles STROB1 stays high per state cycle (>=1)
//  GOT_LEN      1    clk cycles GOT stays high per state cycle (>=1)
//  MEM_TIMEOUT  255  max clks waiting for mem_ok in a memory state before alarm (>=1, 8-bit counter)
// PORTS
//  clk_sys    in   1   system clock
//  clr_n      in   1   asynchronous, active-low reset
//  start      in   1   one-clk pulse from fetch: begin execution in state PP
//  ewe,ewr,ewp,ewa,ewz,ew$,ewx,ewm,eww  in 1 each  enter-state requests from decoder
//  ekc_1      in   1   cycle end request (decoder sheet 10)
//  ekc_2      in   1   cycle end request (decoder sheet 13)
//  mem_ok     in   1   memory/IO transfer complete (level)
//  pp,we,wr,wp,wa,wz,w$,wx,wm,ww  out 1 each  one-hot execution state (all 0 when idle)
//  mem_req    out  1   high from S1 to MW inclusive while in WR, WW or WM
//  strob1     out  1   strobe 1 (IR load, register writes)
//  strob1b    out  1   strobe 1 back, one clk after strob1 falls
//  strob2     out  1   strobe 2
//  got        out  1   state cycle end window
//  kc         out  1   one-clk pulse: instruction execution finished
//  alarm      out  1   one-clk pulse: mem_ok timeout in a memory state
//  seq_err    out  1   sticky: illegal enter combination; cleared only by reset
// BEHAVIOUR
//  Reset (clr_n=0, async, any time incl. mid-cycle)
//   - all outputs 0; timing FSM -> IDLE; state register cleared; counters cleared.
//  Timing FSM: IDLE -> S1 (STROB_LEN clks, strob1=1) -> S1B (1 clk, strob1b=1)
//   -> MW (memory states only) -> S2 (1 clk, strob2=1) -> GOT (GOT_LEN clks, got=1) -> S1 | IDLE.
//  IDLE
//   - start=1 sets pp=1 and enters S1 on the next edge; strob1 rises 1 clk after start.
//   - start while not IDLE is ignored.
//  MW
//   - entered from S1B only when wr|ww|wm; non-memory states go S1B->S2 directly.
//   - leaves to S2 on the clk after mem_ok=1 is sampled; mem_ok already high in S1B skips MW (0 wait clks).
//   - wait counter reaches MEM_TIMEOUT: one-clk alarm pulse, then proceed to S2 as if mem_ok.
//  Decision: on the last GOT clk, sample ew* and ekc_1|ekc_2.
//   - exactly one ew*, no ekc: state register loads that state (one-hot), FSM -> S1; next state may equal current.
//   - ekc, no ew*: state cleared, FSM -> IDLE, kc=1 for one clk coincident with IDLE entry.
//   - ekc together with any ew*: ekc wins (end cycle as above); seq_err set.
//   - >1 ew*, no ekc: seq_err set; lowest in order WE,WR,WP,WA,WZ,W$,WX,WM,WW wins.
//   - no ew*, no ekc: seq_err set; treated as cycle end (kc pulse, IDLE).
//  Exclusivity: state outputs are one-hot or all-zero at all times; they change only at the GOT->S1/IDLE edge.
//  Cycle length per state: STROB_LEN+2+GOT_LEN clks, plus MW clks for memory states.
// STRUCTURE
//  exec_seq_pkg
//   - state index constants ST_PP..ST_WW (10-bit one-hot vector ordering)
//   - timing FSM encoding T_IDLE,T_S1,T_S1B,T_MW,T_S2,T_GOT
//   - priority-encode function for ew*.
//  Sub-module strob_gen: timing FSM + STROB/GOT counters + MW timeout.
//   - inputs: start/continue, mem_state, mem_ok
//   - outputs: strobes, last_got, alarm
//  exec_seq top: state register, decision logic, seq_err/kc.
// TESTING
//  1 Reset/start: clr_n low mid-S1 with we=1 -> all outputs 0 same clk; start after release -> strob1 high next clk, pp=1.
//  2 Non-memory chain: start, ewa on PP GOT, ew$ on WA GOT, ekc_1 on W$ GOT.
//     -> pp,wa,w$ each 5 clks (defaults); kc pulse once; then idle.
//  3 Memory wait: state WR, mem_ok asserted 3 clks after entering MW.
//     -> strob2 on 4th clk of MW; mem_req low from S2; WR cycle 8 clks.
//  4 Timeout (MEM_TIMEOUT=4): WW with mem_ok stuck 0 -> alarm 1 clk after 4 MW clks; S2 follows; state then per ew*.
//  5 Conflicts: ewp+ewz on GOT -> wp=1, seq_err=1. ekc_2+ewe -> kc pulse, idle, seq_err stays 1 until clr_n.
//  6 start pulses during busy and on the kc clk -> ignored; a start one clk after IDLE begins a new PP cycle.

Source files
------------

// File: rtl/exec_seq_pkg.sv
// exec_seq_pkg: shared state indices, timing FSM encoding and enter-request priority encoder
// for the P-D execution-phase sequencer.
package exec_seq_pkg;

    localparam int NST   = 10;
    localparam int ST_PP = 0;
    localparam int ST_WE = 1;
    localparam int ST_WR = 2;
    localparam int ST_WP = 3;
    localparam int ST_WA = 4;
    localparam int ST_WZ = 5;
    localparam int ST_WD = 6;
    localparam int ST_WX = 7;
    localparam int ST_WM = 8;
    localparam int ST_WW = 9;

    typedef enum logic [2:0] {T_IDLE, T_S1, T_S1B, T_MW, T_S2, T_GOT} tstate_t;

    // Keeps only the lowest set bit, so WE beats WR beats ... WW.
    function automatic logic [NST-1:0] prio_enc(input logic [NST-1:0] v);
        return v & (-v);
    endfunction

endpackage

// File: rtl/exec_seq_strob_gen.sv
// exec_seq_strob_gen: per-state-cycle timing FSM producing STROB1/STROB1B/STROB2/GOT,
// with the memory wait phase and its timeout alarm.
module exec_seq_strob_gen
    import exec_seq_pkg::*;
#(
    parameter int STROB_LEN   = 2,
    parameter int GOT_LEN     = 1,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic clk_sys,
    input  logic clr_n,
    input  logic i_go,
    input  logic i_cont,
    input  logic i_mem,
    input  logic i_mem_ok,
    output logic o_idle,
    output logic o_mem_phase,
    output logic o_strob1,
    output logic o_strob1b,
    output logic o_strob2,
    output logic o_got,
    output logic o_last_got,
    output logic o_alarm
);

    tstate_t    r_t;
    tstate_t    w_nt;
    logic [7:0] r_cnt;
    logic       w_to;

    assign w_to = r_cnt == 8'(MEM_TIMEOUT);

    // One counter serves S1 length, MW wait and GOT length; it restarts on every phase change.
    always_ff @(posedge clk_sys or negedge clr_n) begin
        if (!clr_n) begin
            r_t   <= T_IDLE;
            r_cnt <= '0;
        end else begin
            r_t   <= w_nt;
            r_cnt <= (w_nt == r_t) ? r_cnt + 8'd1 : 8'd0;
        end
    end

    always_comb begin
        w_nt = r_t;
        case (r_t)
            T_IDLE:  if (i_go) w_nt = T_S1;
            T_S1:    if (r_cnt == 8'(STROB_LEN - 1)) w_nt = T_S1B;
            T_S1B:   w_nt = (i_mem && !i_mem_ok) ? T_MW : T_S2;
            T_MW:    if (i_mem_ok || w_to) w_nt = T_S2;
            T_S2:    w_nt = T_GOT;
            T_GOT:   if (o_last_got) w_nt = i_cont ? T_S1 : T_IDLE;
            default: w_nt = T_IDLE;
        endcase
    end

    assign o_idle      = r_t == T_IDLE;
    assign o_mem_phase = (r_t == T_S1) || (r_t == T_S1B) || (r_t == T_MW);
    assign o_strob1    = r_t == T_S1;
    assign o_strob1b   = r_t == T_S1B;
    assign o_strob2    = r_t == T_S2;
    assign o_got       = r_t == T_GOT;
    assign o_last_got  = (r_t == T_GOT) && (r_cnt == 8'(GOT_LEN - 1));
    assign o_alarm     = (r_t == T_MW) && w_to;

endmodule

// File: rtl/exec_seq.sv
// exec_seq: execution-phase sequencer holding the one-hot execution state and deciding,
// at the end of each state cycle, the next state or the end of instruction (kc).
module exec_seq
    import exec_seq_pkg::*;
#(
    parameter int STROB_LEN   = 2,
    parameter int GOT_LEN     = 1,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic clk_sys,
    input  logic clr_n,
    input  logic i_start,
    input  logic i_ewe,
    input  logic i_ewr,
    input  logic i_ewp,
    input  logic i_ewa,
    input  logic i_ewz,
    input  logic i_ewd,
    input  logic i_ewx,
    input  logic i_ewm,
    input  logic i_eww,
    input  logic i_ekc_1,
    input  logic i_ekc_2,
    input  logic i_mem_ok,
    output logic o_pp,
    output logic o_we,
    output logic o_wr,
    output logic o_wp,
    output logic o_wa,
    output logic o_wz,
    output logic o_wd,
    output logic o_wx,
    output logic o_wm,
    output logic o_ww,
    output logic o_mem_req,
    output logic o_strob1,
    output logic o_strob1b,
    output logic o_strob2,
    output logic o_got,
    output logic o_kc,
    output logic o_alarm,
    output logic o_seq_err
);

    logic [NST-1:0] r_state;
    logic [NST-1:0] w_ew;
    logic           r_kc;
    logic           r_err;
    logic           w_idle;
    logic           w_mem_phase;
    logic           w_last;
    logic           w_go;
    logic           w_ekc;
    logic           w_end;
    logic           w_bad;
    logic           w_mem;

    assign w_ew  = {i_eww, i_ewm, i_ewx, i_ewd, i_ewz, i_ewa, i_ewp, i_ewr, i_ewe, 1'b0};
    assign w_ekc = i_ekc_1 | i_ekc_2;
    assign w_end = w_ekc | ~|w_ew;
    assign w_bad = w_ekc ? |w_ew : (~|w_ew | |(w_ew & (w_ew - NST'(1))));
    // A start landing on the kc clock belongs to the finished instruction and is dropped.
    assign w_go  = i_start & w_idle & ~r_kc;
    assign w_mem = r_state[ST_WR] | r_state[ST_WW] | r_state[ST_WM];

    exec_seq_strob_gen #(
        .STROB_LEN  (STROB_LEN),
        .GOT_LEN    (GOT_LEN),
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_strob (
        .clk_sys    (clk_sys),
        .clr_n      (clr_n),
        .i_go       (w_go),
        .i_cont     (~w_end),
        .i_mem      (w_mem),
        .i_mem_ok   (i_mem_ok),
        .o_idle     (w_idle),
        .o_mem_phase(w_mem_phase),
        .o_strob1   (o_strob1),
        .o_strob1b  (o_strob1b),
        .o_strob2   (o_strob2),
        .o_got      (o_got),
        .o_last_got (w_last),
        .o_alarm    (o_alarm)
    );

    always_ff @(posedge clk_sys or negedge clr_n) begin
        if (!clr_n) begin
            r_state <= '0;
            r_kc    <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_kc  <= w_last & w_end;
            r_err <= r_err | (w_last & w_bad);
            if (w_go)
                r_state <= NST'(1) << ST_PP;
            else if (w_last)
                r_state <= w_end ? '0 : prio_enc(w_ew);
        end
    end

    assign o_pp      = r_state[ST_PP];
    assign o_we      = r_state[ST_WE];
    assign o_wr      = r_state[ST_WR];
    assign o_wp      = r_state[ST_WP];
    assign o_wa      = r_state[ST_WA];
    assign o_wz      = r_state[ST_WZ];
    assign o_wd      = r_state[ST_WD];
    assign o_wx      = r_state[ST_WX];
    assign o_wm      = r_state[ST_WM];
    assign o_ww      = r_state[ST_WW];
    assign o_mem_req = w_mem & w_mem_phase;
    assign o_kc      = r_kc;
    assign o_seq_err = r_err;

endmodule
